// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: takes the round-10 key and streams round keys
// 10 down to 0 over a valid/ready interface, one per accepted handshake.

module sub_word (
  input  logic [31:0] word,
  output logic [31:0] subbed
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; once out_valid rises, round_key_out/round_num hold until that transfer.
module inv_key_expansion #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] key_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] round_key_out,
  output logic [3:0]    round_num,
  output logic          done
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_n;
  logic [KW-1:0] key_q, key_n;
  logic [3:0]    round_q, round_n;
  logic          done_q, done_n;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1_p, w2_p, w3_p, w0_p;
  logic [31:0] sub_rot;
  logic [7:0]  rcon;

  assign {w0, w1, w2, w3} = key_q;

  // Undo the forward recurrence w[i] = w[i-4] ^ f(w[i-1]) one word at a time.
  assign w3_p = w3 ^ w2;
  assign w2_p = w2 ^ w1;
  assign w1_p = w1 ^ w0;

  sub_word u_sub_word (
    .word   ({w3_p[23:0], w3_p[31:24]}),
    .subbed (sub_rot)
  );

  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0_p = w0 ^ sub_rot ^ {rcon, 24'h000000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      key_q   <= key_n;
      round_q <= round_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = key_q;
    round_n = round_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          key_n   = key_in;
          round_n = 4'(NR);
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (round_q == 4'd0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            key_n   = {w0_p, w1_p, w2_p, w3_p};
            round_n = round_q - 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == EMIT);
  assign round_key_out = key_q;
  assign round_num     = round_q;
  assign done          = done_q;
endmodule

// File: doc/inv_key_expansion.md
Name: inv_key_expansion

Overview:
Sequential AES-128 inverse key schedule. It takes the final round key (round 10) and regenerates the round keys in reverse order, round 10 down to round 0. The decryption datapath consumes them in the order it needs them, so no 11-entry key RAM is stored. It is the decryption-side counterpart of the forward key expansion and reuses the existing SubWord block (four S-Boxes) for its substitution step.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is legal.
- KW, 128, key width in bits; fixed by NR.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, key_in is valid.
- in_ready, output, 1, block can accept a new key; equals (state==IDLE).
- key_in, input, 128, round-10 key; word w0 = bits [127:96], w3 = bits [31:0].
- out_valid, output, 1, round_key_out and round_num are valid.
- out_ready, input, 1, consumer accepts the current round key.
- round_key_out, output, 128, current round key, same word order as key_in.
- round_num, output, 4, round index of round_key_out (10..0).
- done, output, 1, one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, key register=0, round counter=0.
  - out_valid=0, round_key_out=0, round_num=0, done=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-sequence aborts immediately: no further out_valid, no done pulse.
- Two states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, load key_in into the key register, set round=10, go to EMIT.
  - EMIT: in_ready=0, out_valid=1, round_key_out=key register, round_num=round. Inputs on key_in/in_valid are ignored.
- Transitions on out_valid&&out_ready in EMIT:
  - If round==0: go to IDLE and assert done for exactly that next cycle.
  - Else: key register <= prev(key register), round <= round-1, stay in EMIT.
  - Without out_ready, round_key_out and round_num hold stable (standard valid/ready; out_valid never drops before the handshake).
- Latency and throughput:
  - Key accepted at edge N gives out_valid=1 with the round-10 key in the cycle after edge N.
  - With out_ready held high, one key per cycle: 11 keys in 11 consecutive cycles, then done.
  - A new key can be accepted in the cycle done is high (in_ready=1), so back-to-back sequences are allowed.
- prev() for current key {w0,w1,w2,w3} at round r (1..10); all XORs are 32-bit:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}
  - RotWord({a,b,c,d}) = {b,c,d,a}, bytes with a most significant.
  - SubWord is applied byte-wise via the existing SubWord block (combinational, same cycle).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex), indexed by the current round counter, not by a separate counter.
- Boundaries:
  - The round counter never wraps below 0; round 0 is the last emitted key.
  - If out_ready is asserted in IDLE, it has no effect.
  - If in_valid is held high during EMIT, it is not accepted; it is accepted on the first IDLE cycle.

Test Plan:
- FIPS-197 A.1 sequence: reset, then key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 with in_valid=1, out_ready=1.
  - Cycle+1: round 10, same value.
  - Cycle+2: round 9 = ac7766f319fadc2128d12941575c006e.
  - Cycle+11: round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Cycle+12: done=1 for one cycle, out_valid=0.
- Backpressure: same key, out_ready toggled 1,0,0,1 pseudo-randomly -> round_key_out/round_num stable while out_ready=0; the full 11-key sequence is identical to the first test; total cycles = 11 + number of stall cycles.
- Reset mid-sequence: assert rst after round 6 is emitted -> next cycle out_valid=0, round_num=0, round_key_out=0, in_ready=1, no done pulse.
- Back-to-back: present a second key (all-zero expansion round-10 key b4ef5bcb3e92e21123e951cf6f8f188e) in the cycle done=1 -> accepted immediately; final key emitted = 00000000000000000000000000000000.
- in_valid held high throughout EMIT with a different key_in -> ignored; output sequence unaffected; the second key is accepted only when in_ready=1.
- Reset values: hold rst for 3 cycles with random inputs -> out_valid=0, done=0, round_num=0, round_key_out=0 throughout; in_ready=1 after release.
